// File: rtl/ls_arbiter.sv
// Local-store SRAM arbiter: LS/DMA/IF requesters, starvation promotion,
// registered SRAM port and a tagged read-return path with IF flush.
module ls_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [127:0]      ls_wdata,
  output logic              ls_gnt,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [127:0]      dma_wdata,
  output logic              dma_gnt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  input  logic              flush,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  output logic              rd_valid,
  output logic [1:0]        rd_src,
  output logic [127:0]      rd_data
);

  localparam logic [2:0] LIMIT = STARVE_LIMIT[2:0];

  typedef enum logic [1:0] {
    SRC_LS  = 2'd0,
    SRC_DMA = 2'd1,
    SRC_IF  = 2'd2
  } src_e;

  logic [2:0]        dma_cnt_q, dma_cnt_d;
  logic [2:0]        if_cnt_q, if_cnt_d;
  logic              if_ok;
  logic              dma_starved;
  logic              if_starved;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [127:0]      sel_wdata;
  src_e              sel_src;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [127:0]      mem_wdata_q;
  logic              t1_v_q, t2_v_q;
  src_e              t1_src_q, t2_src_q;
  logic              t1_kill, t2_kill;
  logic              rd_valid_q;
  src_e              rd_src_q;
  logic [127:0]      rd_data_q;

  always_comb begin
    ls_gnt      = 1'b0;
    dma_gnt     = 1'b0;
    if_gnt      = 1'b0;
    if_ok       = if_req && !flush;
    dma_starved = dma_req && (dma_cnt_q >= LIMIT);
    if_starved  = if_ok && (if_cnt_q >= LIMIT);
    if (!reset) begin
      if (dma_starved)     dma_gnt = 1'b1;
      else if (if_starved) if_gnt  = 1'b1;
      else if (ls_req)     ls_gnt  = 1'b1;
      else if (dma_req)    dma_gnt = 1'b1;
      else if (if_ok)      if_gnt  = 1'b1;
    end
  end

  assign any_gnt = ls_gnt | dma_gnt | if_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_src   = SRC_LS;
    unique case (1'b1)
      ls_gnt: begin
        sel_we    = ls_we;
        sel_addr  = ls_addr;
        sel_wdata = ls_wdata;
        sel_src   = SRC_LS;
      end
      dma_gnt: begin
        sel_we    = dma_we;
        sel_addr  = dma_addr;
        sel_wdata = dma_wdata;
        sel_src   = SRC_DMA;
      end
      if_gnt: begin
        sel_addr  = if_addr;
        sel_src   = SRC_IF;
      end
      default: ;
    endcase
  end

  always_comb begin
    dma_cnt_d = dma_cnt_q;
    if_cnt_d  = if_cnt_q;
    if (!dma_req || dma_gnt)
      dma_cnt_d = '0;
    else if (dma_cnt_q != 3'd7)
      dma_cnt_d = dma_cnt_q + 3'd1;
    if (!if_req || if_gnt || flush)
      if_cnt_d = '0;
    else if (if_cnt_q != 3'd7)
      if_cnt_d = if_cnt_q + 3'd1;
  end

  // flush squashes IF reads still in either tag stage
  assign t1_kill = flush && (t1_src_q == SRC_IF);
  assign t2_kill = flush && (t2_src_q == SRC_IF);

  always_ff @(posedge clk) begin
    if (reset) begin
      dma_cnt_q   <= '0;
      if_cnt_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      t1_v_q      <= 1'b0;
      t1_src_q    <= SRC_LS;
      t2_v_q      <= 1'b0;
      t2_src_q    <= SRC_LS;
      rd_valid_q  <= 1'b0;
      rd_src_q    <= SRC_LS;
      rd_data_q   <= '0;
    end else begin
      dma_cnt_q  <= dma_cnt_d;
      if_cnt_q   <= if_cnt_d;
      mem_en_q   <= any_gnt;
      mem_we_q   <= any_gnt && sel_we;
      if (any_gnt) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      t1_v_q     <= any_gnt && !sel_we;
      t1_src_q   <= sel_src;
      t2_v_q     <= t1_v_q && !t1_kill;
      t2_src_q   <= t1_src_q;
      rd_valid_q <= t2_v_q && !t2_kill;
      if (t2_v_q && !t2_kill) begin
        rd_src_q  <= t2_src_q;
        rd_data_q <= mem_rdata;
      end
    end
  end

  // outputs read as idle/zero for the whole time reset is high
  assign mem_en    = mem_en_q && !reset;
  assign mem_we    = mem_we_q && !reset;
  assign mem_addr  = reset ? '0 : mem_addr_q;
  assign mem_wdata = reset ? '0 : mem_wdata_q;
  assign rd_valid  = rd_valid_q && !reset;
  assign rd_src    = reset ? 2'd0 : rd_src_q;
  assign rd_data   = reset ? '0 : rd_data_q;

endmodule

// File: doc/ls_arbiter.md
LS_ARBITER -- requirements
Module: ls_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, quadword address width (2048 x 128-bit local store).
REQ-002 Parameter STARVE_LIMIT, default 7, wait cycles after which a low-priority requester is promoted.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ls_req, ls_we  input  1 each  load/store pipe request; ls_we=1 means store.
REQ-006 ls_addr  input  ADDR_W  load/store quadword address.
REQ-007 ls_wdata  input  128  load/store store data.
REQ-008 ls_gnt  output  1  load/store request accepted this cycle.
REQ-009 dma_req, dma_we  input  1 each  DMA request; dma_we=1 means write.
REQ-010 dma_addr  input  ADDR_W  DMA quadword address.
REQ-011 dma_wdata  input  128  DMA write data.
REQ-012 dma_gnt  output  1  DMA request accepted this cycle.
REQ-013 if_req  input  1  instruction-fetch read request; IF never writes.
REQ-014 if_addr  input  ADDR_W  instruction-fetch quadword address.
REQ-015 if_gnt  output  1  IF request accepted this cycle.
REQ-016 flush  input  1  branch taken; cancels IF traffic.
REQ-017 mem_en, mem_we  output  1 each  registered SRAM enable and write strobe.
REQ-018 mem_addr  output  ADDR_W  registered SRAM address.
REQ-019 mem_wdata  output  128  registered SRAM write data.
REQ-020 mem_rdata  input  128  SRAM read data, valid the cycle after a read (mem_en=1, mem_we=0).
REQ-021 rd_valid  output  1  registered read-return strobe.
REQ-022 rd_src  output  2  read-return owner: 0 = LS, 1 = DMA, 2 = IF.
REQ-023 rd_data  output  128  registered read data.

Function
REQ-024 Grants are combinational from the current-cycle requests and state; at most one of ls_gnt, dma_gnt, if_gnt is 1 per cycle.
REQ-025 A requester holds req, we, addr and wdata stable until it receives its grant.
REQ-026 Base priority is LS, then DMA, then IF.
REQ-027 The DMA and IF wait counters are 3-bit and saturating; each increments in any cycle its req=1 and it is not granted, and clears to 0 on grant or when req=0.
REQ-028 A requester whose counter equals STARVE_LIMIT is starved and outranks LS; if both are starved, DMA wins.
REQ-029 While flush=1, if_gnt is 0 and the IF counter clears.
REQ-030 The cycle after grant cycle N, mem_en=1 and mem_we/mem_addr/mem_wdata carry the granted request; mem_en=0 in any cycle following a no-grant cycle.
REQ-031 A granted read produces rd_valid=1 exactly at cycle N+3, with rd_data = mem_rdata from cycle N+2 and rd_src set to the owner.
REQ-032 A granted write produces no rd_valid.
REQ-033 A 2-stage source-tag pipeline tracks in-flight reads; back-to-back grants sustain one access per cycle with no bubbles.
REQ-034 flush=1 invalidates every in-flight IF read (tag stages and return stage), so no rd_valid with rd_src=2 results from grants issued before or during the flush cycle.
REQ-035 Flush does not affect in-flight LS or DMA reads.
REQ-036 When rd_valid=0, rd_data and rd_src hold their previous values.
REQ-037 No address-conflict checking is performed; access order on the SRAM equals grant order.

Reset
REQ-038 While reset=1: all grants are 0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, rd_src=0, rd_data=0, both counters=0, and all tag stages are invalid.
REQ-039 Reset asserted while reads are in flight drops them; no rd_valid appears after reset deasserts until new grants age through the pipeline.
REQ-040 The first grant is possible in the first cycle with reset=0.

Verification
REQ-041 ls_req read addr 0x005 granted at cycle 10, SRAM model returns 0xA5.. -> mem_en=1 at cycle 11, rd_valid=1 at cycle 13 with rd_src=0, rd_data=0xA5...
REQ-042 ls_req, dma_req and if_req held continuously from cycle 0 -> ls_gnt every cycle until DMA counter reaches 7, then one dma_gnt; if_gnt after IF counter saturates and DMA is not starved.
REQ-043 DMA and IF both starved at 7 in the same cycle -> dma_gnt=1, then if_gnt=1 the next cycle (IF still starved), with LS blocked both cycles.
REQ-044 IF read granted at cycle 20, flush=1 at cycle 21 -> no rd_valid at cycle 23; an LS read granted at cycle 21 still returns at cycle 24.
REQ-045 DMA write addr 0x7FF data 0x1234.. at cycle 5, LS read 0x7FF granted at cycle 6 -> mem_we=1 at cycle 6, rd_valid at cycle 9 with rd_data=0x1234...
REQ-046 Reset=1 at cycle 31 with three reads granted at cycles 28-30 -> rd_valid=0 at cycles 31-33 and all counters read 0.
